// File: rtl/pr_free_list_pkg.sv
// Shared constants and types for the physical-register free list.
// Default sizing is 64 physical, 32 architectural registers and 4 lanes each way.
package pr_free_list_pkg;

    localparam int NUM_PR_DEF  = 64;
    localparam int NUM_AR_DEF  = 32;
    localparam int ALLOC_W_DEF = 4;
    localparam int FREE_W_DEF  = 4;
    localparam int PR_W_DEF    = $clog2(NUM_PR_DEF);
    localparam int PTR_W_DEF   = $clog2(NUM_PR_DEF - NUM_AR_DEF) + 1;

    typedef logic [PR_W_DEF-1:0]  pr_num_t;
    typedef logic [PTR_W_DEF-1:0] fl_ptr_t;

endpackage

// File: rtl/fl_compact.sv
// Lane compaction helper: exclusive prefix popcount of a lane mask plus its total.
// offset[i] is the slot a set lane i takes among the set lanes below it.
module fl_compact #(
    parameter int W     = 4,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]            mask,
    output logic [W-1:0][CNT_W-1:0] offset,
    output logic [CNT_W-1:0]        total
);

    logic [CNT_W-1:0] pfx [W+1];

    assign pfx[0] = '0;

    for (genvar gi = 0; gi < W; gi++) begin : g_lane
        assign pfx[gi+1]  = pfx[gi] + CNT_W'(mask[gi]);
        assign offset[gi] = pfx[gi];
    end

    assign total = pfx[W];

endmodule

// File: rtl/pr_free_list.sv
// Circular free list of physical register numbers with multi-lane alloc/free and flush rollback.
// Optional sticky protocol checking is built only when FREELIST_ERR_CHECK_EN is defined.
module pr_free_list
    import pr_free_list_pkg::*;
#(
    parameter int NUM_PR  = NUM_PR_DEF,
    parameter int NUM_AR  = NUM_AR_DEF,
    parameter int ALLOC_W = ALLOC_W_DEF,
    parameter int FREE_W  = FREE_W_DEF,
    localparam int DEPTH  = NUM_PR - NUM_AR,
    localparam int PR_W   = $clog2(NUM_PR),
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int PTR_W  = IDX_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [ALLOC_W-1:0]      alloc_req,
    input  logic [FREE_W-1:0]       free_vld,
    input  logic [FREE_W*PR_W-1:0]  free_pr,
    input  logic                    flush,
    input  logic [PTR_W-1:0]        flush_pos,
    output logic [ALLOC_W*PR_W-1:0] pr_out,
    output logic                    alloc_gnt,
    output logic                    list_empty,
    output logic [PTR_W-1:0]        free_cnt,
    output logic [PTR_W-1:0]        curr_pos,
    output logic                    err
);

    localparam int ACNT_W = $clog2(ALLOC_W + 1);
    localparam int FCNT_W = $clog2(FREE_W + 1);

    // Reset-initialised and read on many ports at once, so this lives in registers.
    logic [PR_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;

    logic [ALLOC_W-1:0][ACNT_W-1:0] a_off;
    logic [ACNT_W-1:0]              a_cnt;
    logic [FREE_W-1:0][FCNT_W-1:0]  f_off;
    logic [FCNT_W-1:0]              f_cnt;

    logic [PTR_W-1:0]  eff_head, room, f_adv;
    logic [FREE_W-1:0] f_keep;
    logic [IDX_W-1:0]  wr_idx [FREE_W];
    logic              f_overflow;

    fl_compact #(.W(ALLOC_W), .CNT_W(ACNT_W)) u_alloc_cmp (
        .mask   (alloc_req),
        .offset (a_off),
        .total  (a_cnt)
    );

    fl_compact #(.W(FREE_W), .CNT_W(FCNT_W)) u_free_cmp (
        .mask   (free_vld),
        .offset (f_off),
        .total  (f_cnt)
    );

    assign free_cnt   = tail_reg - head_reg;
    assign list_empty = (free_cnt == '0);
    assign curr_pos   = head_reg;
    assign alloc_gnt  = !stall && !flush && (a_cnt != '0) && (32'(free_cnt) >= 32'(a_cnt));

    for (genvar gi = 0; gi < ALLOC_W; gi++) begin : g_alloc
        logic [PTR_W-1:0] rd_ptr;
        assign rd_ptr = head_reg + PTR_W'(a_off[gi]);
        assign pr_out[gi*PR_W +: PR_W] = alloc_req[gi] ? mem[rd_ptr[IDX_W-1:0]] : '0;
    end

    // Room is measured against the post-flush head so reclaimed slots count as occupied.
    assign eff_head   = flush ? flush_pos : head_reg;
    assign room       = PTR_W'(DEPTH) - (tail_reg - eff_head);
    assign f_overflow = 32'(f_cnt) > 32'(room);
    assign f_adv      = f_overflow ? room : PTR_W'(f_cnt);

    for (genvar gi = 0; gi < FREE_W; gi++) begin : g_free
        logic [PTR_W-1:0] wr_ptr;
        assign wr_ptr     = tail_reg + PTR_W'(f_off[gi]);
        assign wr_idx[gi] = wr_ptr[IDX_W-1:0];
        assign f_keep[gi] = free_vld[gi] && (32'(f_off[gi]) < 32'(room));
    end

    assign head_next = flush     ? flush_pos
                     : alloc_gnt ? head_reg + PTR_W'(a_cnt)
                     :             head_reg;
    assign tail_next = tail_reg + f_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg <= '0;
            tail_reg <= PTR_W'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PR_W'(NUM_AR + i);
            end
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            for (int li = 0; li < FREE_W; li++) begin
                if (f_keep[li]) begin
                    mem[wr_idx[li]] <= free_pr[li*PR_W +: PR_W];
                end
            end
        end
    end

`ifdef FREELIST_ERR_CHECK_EN
    logic             err_reg;
    logic             bad_pr;
    logic             bad_flush;
    logic [PTR_W-1:0] flush_span;

    always_comb begin
        bad_pr = 1'b0;
        for (int li = 0; li < FREE_W; li++) begin
            if (free_vld[li] && (32'(free_pr[li*PR_W +: PR_W]) < 32'(NUM_AR))) begin
                bad_pr = 1'b1;
            end
        end
    end

    assign flush_span = tail_reg - flush_pos;
    assign bad_flush  = flush && (32'(flush_span) > 32'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_reg | f_overflow | bad_pr | bad_flush;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pr_free_list.sv
// Directed, table-driven bench for pr_free_list at default sizing (64 PR / 32 AR / 4+4 lanes).
// Expected err values follow whether FREELIST_ERR_CHECK_EN is defined for the build.
`timescale 1ns/1ps
module tb_pr_free_list;
    import pr_free_list_pkg::*;

    localparam int PR_W  = PR_W_DEF;
    localparam int PTR_W = PTR_W_DEF;
`ifdef FREELIST_ERR_CHECK_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stall = 1'b0;
    logic [3:0]       alloc_req = '0;
    logic [3:0]       free_vld = '0;
    logic [4*PR_W-1:0] free_pr = '0;
    logic             flush = 1'b0;
    logic [PTR_W-1:0] flush_pos = '0;
    logic [4*PR_W-1:0] pr_out;
    logic             alloc_gnt, list_empty, err;
    logic [PTR_W-1:0] free_cnt, curr_pos;

    int n_vec = 0;
    int n_bad = 0;

    pr_free_list dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .alloc_req  (alloc_req),
        .free_vld   (free_vld),
        .free_pr    (free_pr),
        .flush      (flush),
        .flush_pos  (flush_pos),
        .pr_out     (pr_out),
        .alloc_gnt  (alloc_gnt),
        .list_empty (list_empty),
        .free_cnt   (free_cnt),
        .curr_pos   (curr_pos),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit               rst_first;
        logic             stall;
        logic [3:0]       areq;
        logic [3:0]       fvld;
        logic [4*PR_W-1:0] fpr;
        logic             flush;
        logic [PTR_W-1:0] fpos;
        logic [4*PR_W-1:0] e_pr;
        logic             e_gnt;
        logic             e_empty;
        logic [PTR_W-1:0] e_fc;
        logic [PTR_W-1:0] e_pos;
        logic             e_err;
    } vec_t;

    vec_t tbl [$];

    // Lanes listed 3..0, packed into the flat lane bus.
    function automatic logic [4*PR_W-1:0] p4(input int l3, input int l2, input int l1, input int l0);
        return {pr_num_t'(l3), pr_num_t'(l2), pr_num_t'(l1), pr_num_t'(l0)};
    endfunction

    function automatic vec_t mk(input bit rf, input logic st, input logic [3:0] areq,
                                input logic [3:0] fvld, input logic [4*PR_W-1:0] fpr,
                                input logic fl, input int fpos, input logic [4*PR_W-1:0] e_pr,
                                input logic e_gnt, input logic e_empty, input int e_fc,
                                input int e_pos, input logic e_err);
        vec_t v;
        v.rst_first = rf;   v.stall = st;      v.areq = areq;
        v.fvld = fvld;      v.fpr = fpr;       v.flush = fl;
        v.fpos = fl_ptr_t'(fpos);              v.e_pr = e_pr;
        v.e_gnt = e_gnt;    v.e_empty = e_empty;
        v.e_fc = fl_ptr_t'(e_fc);              v.e_pos = fl_ptr_t'(e_pos);
        v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall = 1'b0; alloc_req = '0; free_vld = '0; free_pr = '0;
        flush = 1'b0; flush_pos = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single-cycle sparse allocation from reset
        tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, '0, 0, 0, p4(0,0,0,0),     0, 0, 32, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1010, 4'b0000, '0, 0, 0, p4(33,0,32,0),   1, 0, 32, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, '0, 0, 0, p4(0,0,0,0),     0, 0, 30, 2, 0));
        // Drain the whole list four at a time
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(mk(k == 0, 0, 4'b1111, 4'b0000, '0, 0, 0,
                             p4(35+4*k, 34+4*k, 33+4*k, 32+4*k), 1, 0, 32-4*k, 4*k, 0));
        end
        tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, '0, 0, 0, p4(35,34,33,32), 0, 1, 0, 32, 0));
        // Frees into an empty list are not allocatable the same cycle
        tbl.push_back(mk(0, 0, 4'b0011, 4'b0101, p4(0,41,0,40), 0, 0, p4(0,0,33,32), 0, 1, 0, 32, 0));
        tbl.push_back(mk(0, 0, 4'b0011, 4'b0000, '0, 0, 0, p4(0,0,41,40),   1, 0, 2, 32, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, '0, 0, 0, p4(0,0,0,0),     0, 1, 0, 34, 0));
        // Allocate 12 then flush back to position 4; flush beats a pending allocation
        tbl.push_back(mk(1, 0, 4'b1111, 4'b0000, '0, 0, 0, p4(35,34,33,32), 1, 0, 32, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, '0, 0, 0, p4(39,38,37,36), 1, 0, 28, 4, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, '0, 0, 0, p4(43,42,41,40), 1, 0, 24, 8, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, '0, 1, 4, p4(47,46,45,44), 0, 0, 20, 12, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, '0, 0, 0, p4(39,38,37,36), 1, 0, 28, 4, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, '0, 0, 0, p4(0,0,0,0),     0, 0, 24, 8, 0));
        // Free into a full list is dropped
        tbl.push_back(mk(1, 0, 4'b0000, 4'b0001, p4(0,0,0,50), 0, 0, p4(0,0,0,0), 0, 0, 32, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, '0, 0, 0, p4(0,0,0,0), 0, 0, 32, 0, ERR_EXP));
        // Stall blocks allocation while frees still land
        tbl.push_back(mk(1, 0, 4'b1111, 4'b0000, '0, 0, 0, p4(35,34,33,32), 1, 0, 32, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b0111, p4(0,34,33,32), 0, 0, p4(39,38,37,36), 0, 0, 28, 4, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, '0, 0, 0, p4(0,0,0,0),     0, 0, 31, 4, 0));
        // Partial overflow: only the lowest lane fits
        tbl.push_back(mk(1, 0, 4'b0001, 4'b0000, '0, 0, 0, p4(0,0,0,32),   1, 0, 32, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b1111, p4(52,51,50,32), 0, 0, p4(0,0,0,0), 0, 0, 31, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, '0, 0, 0, p4(0,0,0,0), 0, 0, 32, 1, ERR_EXP));

        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset();
            stall = tbl[i].stall;  alloc_req = tbl[i].areq;  free_vld = tbl[i].fvld;
            free_pr = tbl[i].fpr;  flush = tbl[i].flush;     flush_pos = tbl[i].fpos;
            @(negedge clk);
            $display("vec %0d areq=%b fvld=%b flush=%0d -> pr_out=%h gnt=%0d fc=%0d pos=%0d err=%0d",
                     i, alloc_req, free_vld, flush, pr_out, alloc_gnt, free_cnt, curr_pos, err);
            chk("pr_out",     i, 32'(pr_out),     32'(tbl[i].e_pr));
            chk("alloc_gnt",  i, 32'(alloc_gnt),  32'(tbl[i].e_gnt));
            chk("list_empty", i, 32'(list_empty), 32'(tbl[i].e_empty));
            chk("free_cnt",   i, 32'(free_cnt),   32'(tbl[i].e_fc));
            chk("curr_pos",   i, 32'(curr_pos),   32'(tbl[i].e_pos));
            chk("err",        i, 32'(err),        32'(tbl[i].e_err));
            step();
        end

        // Reset asserted mid-cycle discards the pending allocation and free
        do_reset();
        alloc_req = 4'b1111;
        step();
        alloc_req = 4'b1111; free_vld = 4'b0001; free_pr = p4(0,0,0,60);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive_idle();
        alloc_req = 4'b1111;
        @(negedge clk);
        $display("seq mid_reset -> pr_out=%h fc=%0d pos=%0d", pr_out, free_cnt, curr_pos);
        chk("mid_reset_pos", 100, 32'(curr_pos), 32'd0);
        chk("mid_reset_fc",  100, 32'(free_cnt), 32'd32);
        chk("mid_reset_pr",  100, 32'(pr_out),   32'(p4(35,34,33,32)));
        step();

        // Freeing an architectural-range PR number
        do_reset();
        alloc_req = 4'b0001;
        step();
        drive_idle();
        free_vld = 4'b0001; free_pr = p4(0,0,0,5);
        step();
        drive_idle();
        @(negedge clk);
        $display("seq bad_free_pr -> fc=%0d err=%0d", free_cnt, err);
        chk("bad_pr_fc",  101, 32'(free_cnt), 32'd32);
        chk("bad_pr_err", 101, 32'(err),      32'(ERR_EXP));
        step();

        // Flush to a position outside the valid window
        do_reset();
        flush = 1'b1; flush_pos = fl_ptr_t'(40);
        step();
        drive_idle();
        @(negedge clk);
        $display("seq bad_flush -> pos=%0d err=%0d", curr_pos, err);
        chk("bad_flush_pos", 102, 32'(curr_pos), 32'd40);
        chk("bad_flush_err", 102, 32'(err),      32'(ERR_EXP));

        do_reset();
        @(negedge clk);
        chk("final_reset_err", 103, 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
